// File: rtl/instruction_issuer_pkg.sv
// Shared definitions for the instruction issuer: instruction layout, opcodes
// and FSM state encoding.
package instruction_issuer_pkg;

    localparam int unsigned INSTR_W = 13;
    localparam int unsigned OP_MSB  = 12;
    localparam int unsigned OP_LSB  = 11;

    typedef enum logic [1:0] {
        OP_STORE = 2'b00,
        OP_LOAD  = 2'b01,
        OP_ADD   = 2'b10,
        OP_MUL   = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic opcode_e instr_op(input logic [INSTR_W-1:0] instr);
        return opcode_e'(instr[OP_MSB:OP_LSB]);
    endfunction

endpackage

// File: rtl/instruction_issuer_prog_buffer.sv
// Program buffer: append-only register array with count, full flag, clear and
// a combinational read port.
module issuer_prog_buffer
    import instruction_issuer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               clear,
    input  logic [PTR_W-1:0]   rd_addr,
    output logic [INSTR_W-1:0] rd_data_c,
    output logic [PTR_W:0]     count,
    output logic               full
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]     count_q;
    logic [PTR_W:0]     count_d;
    logic               full_q;
    logic               full_d;
    logic               wr_take;

    // Clear wins over a write; writes to a full buffer are dropped.
    always_comb begin
        wr_take = wr_en && !clear && !full_q;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (wr_take) begin
            count_d = count_q + (PTR_W+1)'(1);
        end
        full_d = (count_d == (PTR_W+1)'(DEPTH));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Storage is deliberately not reset; contents are only meaningful below count.
    always_ff @(posedge clock) begin
        if (wr_take) begin
            mem_q[count_q[PTR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data_c = mem_q[rd_addr];
    assign count     = count_q;
    assign full      = full_q;

endmodule

// File: rtl/instruction_issuer.sv
// Drives a buffered program onto the processor's instruction_Register, holding
// each instruction for a per-opcode number of cycles.
module instruction_issuer
    import instruction_issuer_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PTR_W     = 4,
    parameter int unsigned CYC_STORE = 4,
    parameter int unsigned CYC_LOAD  = 4,
    parameter int unsigned CYC_ADD   = 4,
    parameter int unsigned CYC_MUL   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               prog_wr_en,
    input  logic [INSTR_W-1:0] prog_wr_data,
    input  logic               prog_clear,
    input  logic               start,
    output logic [PTR_W:0]     prog_count,
    output logic               prog_full,
    output logic               busy,
    output logic [INSTR_W-1:0] instruction_Register,
    output logic               instr_valid,
    output logic               done
);

    localparam int unsigned CYC_MAX_SL = (CYC_STORE > CYC_LOAD) ? CYC_STORE : CYC_LOAD;
    localparam int unsigned CYC_MAX_AM = (CYC_ADD > CYC_MUL) ? CYC_ADD : CYC_MUL;
    localparam int unsigned CYC_MAX    = (CYC_MAX_SL > CYC_MAX_AM) ? CYC_MAX_SL : CYC_MAX_AM;
    localparam int unsigned CNT_W      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    function automatic logic [CNT_W-1:0] hold_of(input logic [INSTR_W-1:0] instr);
        case (instr_op(instr))
            OP_STORE: return CNT_W'(CYC_STORE - 1);
            OP_LOAD:  return CNT_W'(CYC_LOAD - 1);
            OP_ADD:   return CNT_W'(CYC_ADD - 1);
            OP_MUL:   return CNT_W'(CYC_MUL - 1);
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               idle;
    logic               buf_wr;
    logic               buf_clr;
    logic               wr_take;
    logic [PTR_W:0]     eff_count;
    logic               go;
    logic               last;
    logic [PTR_W-1:0]   rd_addr;
    logic [INSTR_W-1:0] buf_rd;
    logic [INSTR_W-1:0] first_instr;

    issuer_prog_buffer #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (buf_wr),
        .wr_data   (prog_wr_data),
        .clear     (buf_clr),
        .rd_addr   (rd_addr),
        .rd_data_c (buf_rd),
        .count     (prog_count),
        .full      (prog_full)
    );

    // A start in the same cycle as a write sees the post-write count, and an
    // empty buffer's first entry comes straight from the write data.
    always_comb begin
        idle        = (state_q == ST_IDLE);
        buf_wr      = idle && prog_wr_en;
        buf_clr     = idle && prog_clear;
        wr_take     = buf_wr && !buf_clr && !prog_full;
        eff_count   = buf_clr ? '0 : prog_count + (PTR_W+1)'(wr_take);
        go          = idle && start && (eff_count != '0);
        last        = ((PTR_W+1)'(rd_ptr_q) + (PTR_W+1)'(1)) == prog_count;
        rd_addr     = idle ? '0 : rd_ptr_q + PTR_W'(1);
        first_instr = (prog_count == '0) ? prog_wr_data : buf_rd;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            hold_q   <= '0;
            ir_q     <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (go) state_d = ST_RUN;
            ST_RUN:  if (hold_q == '0 && last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Hold budget is always decoded from the instruction being loaded.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        hold_d   = hold_q;
        ir_d     = ir_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    ir_d     = first_instr;
                    hold_d   = hold_of(first_instr);
                    rd_ptr_d = '0;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - CNT_W'(1);
                end else if (!last) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    ir_d     = buf_rd;
                    hold_d   = hold_of(buf_rd);
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_DONE: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                rd_ptr_d = '0;
            end
            default: ;
        endcase
    end

    assign instruction_Register = ir_q;
    assign instr_valid          = valid_q;
    assign busy                 = busy_q;
    assign done                 = done_q;

endmodule
